// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial sequence detector family.
package seq_det_pkg;

    // Power-up behaviour: overlapping 11011 detector.
    localparam logic [4:0] DEFAULT_PATTERN = 5'b11011;
    localparam int         DEFAULT_LEN     = 5;
    localparam logic       DEFAULT_OVERLAP = 1'b1;

    // Coerce a requested pattern length into 1..max_len.
    function automatic int unsigned clamp_len(input int unsigned raw_len,
                                              input int unsigned max_len);
        int unsigned r;
        r = raw_len;
        if (r == 0)
            r = 1;
        else if (r > max_len)
            r = max_len;
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc && (q_q != {W{1'b1}}))
            q_d = q_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector with overlap control and
// a saturating match counter.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt
);

    // Only the newest MAX_LEN-1 bits are stored; the bit arriving this cycle
    // completes the MAX_LEN-wide comparison window.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic               out_q,  out_d;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;
    logic               cnt_clr;
    logic               cnt_inc;

    // Window after shifting in the current bit, and the mask of live pattern bits.
    always_comb begin
        hist_n = {hist_q, in};
        fill_n = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (LEN_W'(i) < len_q);
        match = en && (fill_n == len_q) &&
                ((hist_n & len_mask) == (pat_q & len_mask));
    end

    // Next-state: load beats bit sampling; idle cycles hold everything but out.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        out_d   = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            cnt_clr = 1'b1;
        end else if (en) begin
            hist_d  = hist_n[MAX_LEN-2:0];
            fill_d  = (match && !ovl_q) ? '0 : fill_n;
            out_d   = match;
            cnt_inc = match;
        end
    end

    // State registers; reset restores the default 11011 overlapping detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= MAX_LEN'(DEFAULT_PATTERN);
            len_q  <= LEN_W'(DEFAULT_LEN);
            ovl_q  <= DEFAULT_OVERLAP;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            out_q  <= out_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .q   (match_cnt)
    );

    assign out = out_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Table-driven bench for seq_detect_param with a per-cycle scoreboard.
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               bit_in = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               out_w;
    logic [CNT_W-1:0]   cnt_w;

    always #5 clk = ~clk;

    seq_detect_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in          (bit_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .out         (out_w),
        .match_cnt   (cnt_w)
    );

    typedef struct {
        logic               rst;
        logic               load;
        logic               en;
        logic               b;
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
        logic               ovl;
        logic               exp_out;
        logic [CNT_W-1:0]   exp_cnt;
        string              name;
    } vec_t;

    typedef struct {
        logic             o;
        logic [CNT_W-1:0] c;
        string            name;
        int               idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic ld, input logic e, input logic b,
                       input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                       input logic o, input logic eo, input logic [CNT_W-1:0] ec,
                       input string nm);
        vec_t v;
        v.rst = r; v.load = ld; v.en = e; v.b = b;
        v.pat = p; v.len = l; v.ovl = o;
        v.exp_out = eo; v.exp_cnt = ec; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic add_bit(input logic b, input logic eo, input logic [CNT_W-1:0] ec,
                           input string nm);
        add(1'b0, 1'b0, 1'b1, b, 8'hFF, 4'd2, 1'b0, eo, ec, nm);
    endtask

    task automatic add_idle(input logic [CNT_W-1:0] ec, input string nm);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd2, 1'b0, 1'b0, ec, nm);
    endtask

    task automatic add_rst(input string nm);
        add(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b0, 1'b0, 2'd0, nm);
    endtask

    // en and in are held high during loads so an ignored-bit fault shows up.
    task automatic add_load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                            input logic o, input string nm);
        add(1'b0, 1'b1, 1'b1, 1'b1, p, l, o, 1'b0, 2'd0, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        add_rst("reset");

        add_bit(1, 0, 0, "dflt_b1"); add_bit(1, 0, 0, "dflt_b2");
        add_bit(0, 0, 0, "dflt_b3"); add_bit(1, 0, 0, "dflt_b4");
        add_bit(1, 1, 1, "dflt_b5"); add_bit(0, 0, 1, "dflt_b6");
        add_bit(1, 0, 1, "dflt_b7"); add_bit(1, 1, 2, "dflt_b8");

        add_load(8'hF5, 4'd3, 1'b1, "load_101_ovl");
        add_bit(1, 0, 0, "ovl_b1"); add_bit(0, 0, 0, "ovl_b2");
        add_bit(1, 1, 1, "ovl_b3"); add_bit(0, 0, 1, "ovl_b4");
        add_bit(1, 1, 2, "ovl_b5");

        add_load(8'hF5, 4'd3, 1'b0, "load_101_novl");
        add_bit(1, 0, 0, "novl_b1"); add_bit(0, 0, 0, "novl_b2");
        add_bit(1, 1, 1, "novl_b3"); add_bit(0, 0, 1, "novl_b4");
        add_bit(1, 0, 1, "novl_b5");

        add_rst("gap_reset");
        add_bit(1, 0, 0, "gap_b1"); repeat (3) add_idle(0, "gap_idle1");
        add_bit(1, 0, 0, "gap_b2"); repeat (3) add_idle(0, "gap_idle2");
        add_bit(0, 0, 0, "gap_b3"); repeat (3) add_idle(0, "gap_idle3");
        add_bit(1, 0, 0, "gap_b4"); repeat (3) add_idle(0, "gap_idle4");
        add_bit(1, 1, 1, "gap_b5"); repeat (3) add_idle(1, "gap_idle5");

        add_rst("mid_reset_a");
        add_bit(1, 0, 0, "pre_b1"); add_bit(1, 0, 0, "pre_b2");
        add_bit(0, 0, 0, "pre_b3"); add_bit(1, 0, 0, "pre_b4");
        add_rst("mid_reset_b");
        add_bit(1, 0, 0, "post_b1"); add_bit(1, 0, 0, "post_b2");
        add_bit(0, 0, 0, "post_b3"); add_bit(1, 0, 0, "post_b4");
        add_bit(1, 1, 1, "post_b5");

        add_load(8'h01, 4'd0, 1'b1, "load_len0");
        add_bit(1, 1, 1, "sat_b1"); add_bit(1, 1, 2, "sat_b2");
        add_bit(1, 1, 3, "sat_b3"); add_bit(1, 1, 3, "sat_b4");
        add_bit(1, 1, 3, "sat_b5"); add_idle(3, "sat_idle");

        add_load(8'hA5, 4'd11, 1'b1, "load_len_big");
        add_bit(1, 0, 0, "a5_b1"); add_bit(0, 0, 0, "a5_b2");
        add_bit(1, 0, 0, "a5_b3"); add_bit(0, 0, 0, "a5_b4");
        add_bit(0, 0, 0, "a5_b5"); add_bit(1, 0, 0, "a5_b6");
        add_bit(0, 0, 0, "a5_b7"); add_bit(1, 1, 1, "a5_b8");
        add_idle(1, "a5_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(negedge clk);
            rst         = vecs[i].rst;
            cfg_load    = vecs[i].load;
            en          = vecs[i].en;
            bit_in      = vecs[i].b;
            cfg_pattern = vecs[i].pat;
            cfg_len     = vecs[i].len;
            cfg_overlap = vecs[i].ovl;
            e.o = vecs[i].exp_out;
            e.c = vecs[i].exp_cnt;
            e.name = vecs[i].name;
            e.idx = i;
            sb.push_back(e);

            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty[%0d]: got no entry want one", i);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_w !== e.o) begin
                    errors++;
                    $display("FAIL %s[%0d] out: got %b want %b", e.name, e.idx, out_w, e.o);
                end
                checks++;
                if (cnt_w !== e.c) begin
                    errors++;
                    $display("FAIL %s[%0d] match_cnt: got %0d want %0d", e.name, e.idx, cnt_w, e.c);
                end
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
